// File: rtl/voice_scheduler.sv
// Frame sequencer: shares one sample RAM among NUM_VOICES voices, mixes one sample per active voice, writes frame to codec FIFO.
// Latency: N + 2k + 2 cycles from the sampling IDLE cycle to the write strobe; stalls in IDLE while the FIFO is full. Optional macro: VOICE_SCHED_SAT_EN.
module voice_scheduler #(
   parameter int NUM_VOICES = 4,
   parameter int VOICE_LEN  = 100,
   parameter int ADDR_W     = 9
) (
   input  logic                  CLOCK_50,
   input  logic                  reset,
   input  logic [NUM_VOICES-1:0] key_on,
   input  logic                  audio_out_allowed,
   input  logic [31:0]           ram_q,
   output logic [ADDR_W-1:0]     ram_address,
   output logic                  write_audio_out,
   output logic [31:0]           left_channel_audio_out,
   output logic [31:0]           right_channel_audio_out,
   output logic                  busy
);

   localparam int VI_W  = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
   localparam int POS_W = (VOICE_LEN > 1) ? $clog2(VOICE_LEN) : 1;

`ifdef VOICE_SCHED_SAT_EN
   localparam bit SAT_EN = 1'b1;
`else
   localparam bit SAT_EN = 1'b0;
`endif

   typedef enum logic [2:0] {S_IDLE, S_SCAN, S_WAIT, S_ACC, S_OUT} state_t;

   state_t                  r_state;
   logic [NUM_VOICES-1:0]   r_act;
   logic signed [33:0]      r_acc;
   logic [VI_W-1:0]         r_vi;
   logic [POS_W-1:0]        r_pos [NUM_VOICES];
   logic [ADDR_W-1:0]       r_addr;
   logic                    r_wr;
   logic [31:0]             r_left;
   logic [31:0]             r_right;

   logic                    w_last;
   logic [ADDR_W-1:0]       w_base;
   logic [ADDR_W-1:0]       w_addr;
   logic                    w_ovf;
   logic [31:0]             w_frame;

   assign w_last = (r_vi == VI_W'(NUM_VOICES - 1));
   assign w_base = ADDR_W'(r_vi) * ADDR_W'(VOICE_LEN);
   assign w_addr = w_base + ADDR_W'(r_pos[r_vi]);

   // Out of 32-bit range when the top three accumulator bits disagree.
   always_comb begin
      w_ovf   = (r_acc[33:31] != {3{r_acc[33]}});
      w_frame = r_acc[31:0];
      if (SAT_EN && w_ovf)
         w_frame = r_acc[33] ? 32'h8000_0000 : 32'h7FFF_FFFF;
   end

   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_act   <= '0;
         r_acc   <= '0;
         r_vi    <= '0;
         r_addr  <= '0;
         r_wr    <= 1'b0;
         r_left  <= '0;
         r_right <= '0;
         for (int v = 0; v < NUM_VOICES; v++)
            r_pos[v] <= '0;
      end else begin
         r_wr <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (audio_out_allowed && !r_wr) begin
                  r_act   <= key_on;
                  r_acc   <= '0;
                  r_vi    <= '0;
                  r_state <= S_SCAN;
               end
            end
            S_SCAN: begin
               if (r_act[r_vi]) begin
                  r_addr  <= w_addr;
                  r_state <= S_WAIT;
               end else if (w_last) begin
                  r_state <= S_OUT;
               end else begin
                  r_vi <= r_vi + VI_W'(1);
               end
            end
            S_WAIT: r_state <= S_ACC;
            S_ACC: begin
               r_acc <= r_acc + {{2{ram_q[31]}}, ram_q};
               if (w_last) begin
                  r_addr  <= '0;
                  r_state <= S_OUT;
               end else begin
                  r_vi    <= r_vi + VI_W'(1);
                  r_state <= S_SCAN;
               end
            end
            S_OUT: begin
               r_left  <= w_frame;
               r_right <= w_frame;
               r_wr    <= 1'b1;
               r_addr  <= '0;
               // Released voices restart from their first sample.
               for (int v = 0; v < NUM_VOICES; v++) begin
                  if (!r_act[v])
                     r_pos[v] <= '0;
                  else if (r_pos[v] == POS_W'(VOICE_LEN - 1))
                     r_pos[v] <= '0;
                  else
                     r_pos[v] <= r_pos[v] + POS_W'(1);
               end
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign ram_address             = r_addr;
   assign write_audio_out         = r_wr;
   assign left_channel_audio_out  = r_left;
   assign right_channel_audio_out = r_right;
   assign busy                    = (r_state != S_IDLE);

endmodule

// File: tb/tb_voice_scheduler.sv
// Directed bench for voice_scheduler: registered RAM model with q = address, frame-by-frame vector table plus corner sequences.
module tb_voice_scheduler;

   logic        CLOCK_50 = 1'b0;
   logic        reset;
   logic [3:0]  key_on;
   logic        allowed;
   logic [31:0] ram_q;
   logic [8:0]  ram_address;
   logic        write_audio_out;
   logic [31:0] left;
   logic [31:0] right;
   logic        busy;

   logic [31:0] mem [0:511];

   int n_vec = 0;
   int n_bad = 0;

   typedef struct {
      logic [3:0]  key;
      logic [31:0] exp;
      int          cyc;
   } vec_t;

   vec_t tbl [8];

   voice_scheduler #(.NUM_VOICES(4), .VOICE_LEN(100), .ADDR_W(9)) dut (
      .CLOCK_50                (CLOCK_50),
      .reset                   (reset),
      .key_on                  (key_on),
      .audio_out_allowed       (allowed),
      .ram_q                   (ram_q),
      .ram_address             (ram_address),
      .write_audio_out         (write_audio_out),
      .left_channel_audio_out  (left),
      .right_channel_audio_out (right),
      .busy                    (busy)
   );

   always #5 CLOCK_50 = ~CLOCK_50;

   always @(posedge CLOCK_50) ram_q <= mem[ram_address];

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   // Entered at a negedge with the DUT idle; leaves at the next sampling IDLE negedge with allowed low.
   task automatic run_frame(input string name, input logic [3:0] key, input logic [3:0] midkey,
                            input bit drop, input logic [31:0] exp, input int exp_cyc);
      int guard = 0;
      int cyc = 0;
      while ((busy || write_audio_out) && guard < 100) begin
         @(negedge CLOCK_50);
         guard++;
      end
      key_on  = key;
      allowed = 1'b1;
      do begin
         @(negedge CLOCK_50);
         cyc++;
         if (cyc == 2) begin
            key_on = midkey;
            if (drop) allowed = 1'b0;
         end
      end while (!write_audio_out && cyc < 60);
      check({name, "_strobe"}, {31'b0, write_audio_out}, 32'd1);
      check({name, "_left"}, left, exp);
      check({name, "_right"}, right, exp);
      if (exp_cyc > 0) check({name, "_cycles"}, cyc, exp_cyc);
      @(negedge CLOCK_50);
      allowed = 1'b0;
      check({name, "_width"}, {31'b0, write_audio_out}, 32'd0);
      check({name, "_hold"}, left, exp);
   endtask

   task automatic pulse_reset();
      reset = 1'b1;
      repeat (2) @(negedge CLOCK_50);
      reset = 1'b0;
   endtask

   initial begin
      int viol;
      logic [31:0] sat_pos;
      logic [31:0] sat_neg;

      tbl[0] = '{4'b0101, 32'd200, 10};
      tbl[1] = '{4'b0101, 32'd202, 10};
      tbl[2] = '{4'b0101, 32'd204, 10};
      tbl[3] = '{4'b0001, 32'd3,   8};
      tbl[4] = '{4'b1111, 32'd604, 14};
      tbl[5] = '{4'b0000, 32'd0,   6};
      tbl[6] = '{4'b0010, 32'd100, 8};
      tbl[7] = '{4'b1000, 32'd300, 8};

`ifdef VOICE_SCHED_SAT_EN
      sat_pos = 32'h7FFF_FFFF;
      sat_neg = 32'h8000_0000;
`else
      sat_pos = 32'hFFFF_FFFE;
      sat_neg = 32'h0000_0000;
`endif

      for (int a = 0; a < 512; a++) mem[a] = a;
      reset   = 1'b1;
      key_on  = 4'b0000;
      allowed = 1'b0;
      repeat (3) @(negedge CLOCK_50);
      check("rst_write", {31'b0, write_audio_out}, 32'd0);
      check("rst_left", left, 32'd0);
      check("rst_right", right, 32'd0);
      check("rst_addr", {23'b0, ram_address}, 32'd0);
      check("rst_busy", {31'b0, busy}, 32'd0);
      reset = 1'b0;

      for (int i = 0; i < 8; i++)
         run_frame($sformatf("vec%0d", i), tbl[i].key, tbl[i].key, 1'b0, tbl[i].exp, tbl[i].cyc);

      // Single voice walks its region and wraps back to sample 0.
      for (int i = 0; i < 102; i++)
         run_frame($sformatf("wrap%0d", i), 4'b0001, 4'b0001, 1'b0, 32'(i % 100), 8);

      viol = 0;
      repeat (50) begin
         @(negedge CLOCK_50);
         if (write_audio_out || busy) viol++;
      end
      check("bp_idle", viol, 0);
      run_frame("bp_frozen", 4'b0001, 4'b0001, 1'b0, 32'd2, 8);

      run_frame("midkey", 4'b0001, 4'b1111, 1'b1, 32'd3, 8);
      run_frame("midkey_after", 4'b0010, 4'b0010, 1'b0, 32'd100, 8);

      key_on  = 4'b0001;
      allowed = 1'b1;
      repeat (3) @(negedge CLOCK_50);
      check("mid_busy", {31'b0, busy}, 32'd1);
      reset = 1'b1;
      #1;
      check("mid_rst_write", {31'b0, write_audio_out}, 32'd0);
      check("mid_rst_left", left, 32'd0);
      check("mid_rst_right", right, 32'd0);
      check("mid_rst_addr", {23'b0, ram_address}, 32'd0);
      check("mid_rst_busy", {31'b0, busy}, 32'd0);
      allowed = 1'b0;
      viol = 0;
      repeat (3) begin
         @(negedge CLOCK_50);
         if (write_audio_out) viol++;
      end
      check("mid_rst_nowrite", viol, 0);
      reset = 1'b0;
      run_frame("post_rst", 4'b0001, 4'b0001, 1'b0, 32'd0, 8);

      pulse_reset();
      mem[0]   = 32'h7FFF_FFFF;
      mem[100] = 32'h7FFF_FFFF;
      mem[1]   = 32'h8000_0000;
      mem[101] = 32'h8000_0000;
      run_frame("sat_pos", 4'b0011, 4'b0011, 1'b0, sat_pos, 10);
      run_frame("sat_neg", 4'b0011, 4'b0011, 1'b0, sat_neg, 10);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
